// File: rtl/regfile16_bank.sv
// Sixteen-entry register bank with one write port and a sequential clear engine.
// Optional REGFILE_R0_ZERO_EN hardwires register 0 to zero.
module regfile16_bank #(
    parameter int                 WIDTH   = 16,
    parameter logic [WIDTH-1:0]   CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ack,
    input  logic             clr_req,
    output logic             busy,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic [WIDTH-1:0] data_out2,
    output logic [WIDTH-1:0] data_out3,
    output logic [WIDTH-1:0] data_out4,
    output logic [WIDTH-1:0] data_out5,
    output logic [WIDTH-1:0] data_out6,
    output logic [WIDTH-1:0] data_out7,
    output logic [WIDTH-1:0] data_out8,
    output logic [WIDTH-1:0] data_out9,
    output logic [WIDTH-1:0] data_out10,
    output logic [WIDTH-1:0] data_out11,
    output logic [WIDTH-1:0] data_out12,
    output logic [WIDTH-1:0] data_out13,
    output logic [WIDTH-1:0] data_out14,
    output logic [WIDTH-1:0] data_out15
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             do_wr, do_clr;
    logic [WIDTH-1:0] regs_q [16];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        do_wr   = 1'b0;
        do_clr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // clear wins over a same-edge write
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = 4'd0;
                end else if (wr_en) begin
                    do_wr = 1'b1;
                end
            end
            CLEAR: begin
                do_clr = 1'b1;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_ack  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_ack  <= do_wr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else if (do_clr) begin
            regs_q[cnt_q] <= CLR_VAL;
        end else if (do_wr) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign busy = (state_q == CLEAR);

`ifdef REGFILE_R0_ZERO_EN
    assign data_out0 = '0;
`else
    assign data_out0 = regs_q[0];
`endif
    assign data_out1  = regs_q[1];
    assign data_out2  = regs_q[2];
    assign data_out3  = regs_q[3];
    assign data_out4  = regs_q[4];
    assign data_out5  = regs_q[5];
    assign data_out6  = regs_q[6];
    assign data_out7  = regs_q[7];
    assign data_out8  = regs_q[8];
    assign data_out9  = regs_q[9];
    assign data_out10 = regs_q[10];
    assign data_out11 = regs_q[11];
    assign data_out12 = regs_q[12];
    assign data_out13 = regs_q[13];
    assign data_out14 = regs_q[14];
    assign data_out15 = regs_q[15];

endmodule

// File: tb/tb_regfile16_bank.sv
// Self-checking bench for regfile16_bank: vector table, corner sequences
// and randomized traffic against a behavioural register-bank model.
module tb_regfile16_bank;

    localparam logic [15:0] CV = 16'h1234;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [15:0] wr_data = 16'd0;
    logic        clr_req = 1'b0;
    logic        wr_ack;
    logic        busy;
    logic [15:0] dout [16];

    int checks = 0;
    int errors = 0;

    logic [15:0] m [16];
    int          clr_left;
    bit          e_ack;

    typedef struct {
        bit          we;
        logic [3:0]  a;
        logic [15:0] d;
        bit          exp_ack;
        int          idx;
        logic [15:0] exp_val;
    } vec_t;

    vec_t tbl [20];

    regfile16_bank #(.WIDTH(16), .CLR_VAL(CV)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .clr_req(clr_req), .busy(busy),
        .data_out0(dout[0]),   .data_out1(dout[1]),
        .data_out2(dout[2]),   .data_out3(dout[3]),
        .data_out4(dout[4]),   .data_out5(dout[5]),
        .data_out6(dout[6]),   .data_out7(dout[7]),
        .data_out8(dout[8]),   .data_out9(dout[9]),
        .data_out10(dout[10]), .data_out11(dout[11]),
        .data_out12(dout[12]), .data_out13(dout[13]),
        .data_out14(dout[14]), .data_out15(dout[15])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] r0fix(input int idx,
                                          input logic [15:0] v);
`ifdef REGFILE_R0_ZERO_EN
        return (idx == 0) ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i] = 16'h0;
        clr_left = 0;
        e_ack = 1'b0;
    endtask

    // One rising edge of the abstract bank
    task automatic model_edge(input bit we, input logic [3:0] a,
                              input logic [15:0] d, input bit clr);
        e_ack = 1'b0;
        if (clr_left > 0) begin
            m[16 - clr_left] = r0fix(16 - clr_left, CV);
            clr_left--;
        end else if (clr) begin
            clr_left = 16;
        end else if (we) begin
            m[a] = r0fix(int'(a), d);
            e_ack = 1'b1;
        end
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s data_out%0d", tag, i), dout[i], m[i]);
        chk({tag, " wr_ack"}, wr_ack, e_ack);
        chk({tag, " busy"}, busy, clr_left > 0);
    endtask

    task automatic step(input string tag, input bit we, input logic [3:0] a,
                        input logic [15:0] d, input bit clr);
        wr_en = we;
        wr_addr = a;
        wr_data = d;
        clr_req = clr;
        @(posedge clk);
        model_edge(we, a, d, clr);
        #1;
        compare_all(tag);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        compare_all("reset");

        for (int i = 0; i < 16; i++)
            tbl[i] = '{1'b1, 4'(i), 16'(16 * (i + 1)), 1'b1, i,
                       r0fix(i, 16'(16 * (i + 1)))};
        tbl[16] = '{1'b1, 4'd5, 16'h00A0, 1'b1, 5, 16'h00A0};
        tbl[17] = '{1'b0, 4'd5, 16'hDEAD, 1'b0, 5, 16'h00A0};
        tbl[18] = '{1'b1, 4'd5, 16'hBEEF, 1'b1, 5, 16'hBEEF};
        tbl[19] = '{1'b0, 4'd0, 16'h0000, 1'b0, 5, 16'hBEEF};
        for (int k = 0; k < 20; k++) begin
            step($sformatf("vec%0d", k), tbl[k].we, tbl[k].a, tbl[k].d, 1'b0);
            chk($sformatf("vec%0d ack", k), wr_ack, tbl[k].exp_ack);
            chk($sformatf("vec%0d val", k), dout[tbl[k].idx], tbl[k].exp_val);
        end
        chk("sweep data_out15", dout[15], 16'h0100);

        step("clr_start", 1'b0, 4'd0, 16'h0, 1'b1);
        n = 1;
        while (busy && n < 40) begin
            if (n == 2) step("clr_mid_wr", 1'b1, 4'd3, 16'hFFFF, 1'b0);
            else        step("clr_run", 1'b0, 4'd0, 16'h0, 1'b0);
            if (busy) n++;
        end
        chk("clr busy cycles", n, 16);
        chk("clr data_out3", dout[3], 16'h1234);
        chk("clr data_out15", dout[15], 16'h1234);

        step("after_clr_wr", 1'b1, 4'd9, 16'h0999, 1'b0);
        chk("after_clr ack", wr_ack, 1'b1);

        step("prio", 1'b1, 4'd7, 16'h5555, 1'b1);
        chk("prio ack", wr_ack, 1'b0);
        chk("prio busy", busy, 1'b1);
        repeat (16) step("prio_run", 1'b0, 4'd0, 16'h0, 1'b0);
        chk("prio data_out7", dout[7], CV);
        chk("prio done", busy, 1'b0);

        step("seed", 1'b1, 4'd12, 16'hC0DE, 1'b0);
        step("rst_clr", 1'b0, 4'd0, 16'h0, 1'b1);
        repeat (8) step("rst_run", 1'b0, 4'd0, 16'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_wr", 1'b1, 4'd2, 16'h0042, 1'b0);
        chk("rst_wr data_out2", dout[2], 16'h0042);
        chk("rst_wr ack", wr_ack, 1'b1);

        for (int r = 0; r < 400; r++) begin
            bit we, clr;
            we = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 24) == 0);
            if (we)
                step("rand", we, 4'($urandom), 16'($urandom), clr);
            else
                step("rand", we, 4'bx, 16'bx, clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
